// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock parametrised FIFO.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple-dual-port storage: synchronous write, asynchronous (LUT) read, no reset.
module fifo_ram_sdp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable thresholds, std/FWFT read and flush.
// Optional sticky overflow/underflow outputs when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  fifo_rst,
    input  logic                  fifo_en,
    input  logic                  fifo_clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] wr_add,
    output logic [ADDR_WIDTH-1:0] rd_add
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] ONE_C = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_C  = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C  = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_acc, rd_acc, ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // MSB is the wrap bit: equal low bits with differing MSBs means a full lap ahead.
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign wr_add       = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_add       = rd_ptr_q[ADDR_WIDTH-1:0];

    assign wr_acc = fifo_en & wr_en & ~full;
    assign rd_acc = fifo_en & rd_en & ~empty;
    assign ram_we = wr_acc & ~fifo_rst & ~fifo_clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
        if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (fifo_clr) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Masked while empty so the head reads as zero out of reset.
        assign rd_data  = empty ? '0 : ram_rdata;
        assign rd_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk) begin
            if (fifo_rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (fifo_clr) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) rd_data_q <= ram_rdata;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (fifo_rst || fifo_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (fifo_en & wr_en & full);
            underflow_q <= underflow_q | (fifo_en & rd_en & empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: standard-mode instance plus an FWFT instance.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        fifo_rst = 1'b0;
    logic        fifo_en = 1'b0, fifo_clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0]  count;
    logic [3:0]  wr_add, rd_add;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic        overflow, underflow;
    logic        f_overflow, f_underflow;
`endif

    logic        f_en = 1'b0, f_clr = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [31:0] f_wr_data = '0;
    logic [31:0] f_rd_data;
    logic        f_rd_valid, f_full, f_empty, f_af, f_ae;
    logic [4:0]  f_count;
    logic [3:0]  f_wr_add, f_rd_add;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] sb_q[$];
    int          m_count = 0;
    logic [3:0]  m_wr = '0, m_rd = '0;
    logic [31:0] m_last = '0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(0)) u_std (
        .clk(clk), .fifo_rst(fifo_rst), .fifo_en(fifo_en), .fifo_clr(fifo_clr),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .wr_add(wr_add), .rd_add(rd_add)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    sync_fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .fifo_rst(fifo_rst), .fifo_en(f_en), .fifo_clr(f_clr),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en), .rd_data(f_rd_data),
        .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .wr_add(f_wr_add), .rd_add(f_rd_add)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(f_overflow), .underflow(f_underflow)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state();
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == 16));
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("almost_full", 32'(almost_full), 32'(m_count >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
        chk("wr_add", 32'(wr_add), 32'(m_wr));
        chk("rd_add", 32'(rd_add), 32'(m_rd));
    endtask

    // One standard-mode cycle; the model decides acceptance from pre-edge occupancy.
    task automatic std_cycle(input logic en, input logic w, input logic [31:0] d, input logic r);
        logic wacc, racc;
        fifo_en = en; wr_en = w; wr_data = d; rd_en = r;
        wacc = en && w && (m_count != 16);
        racc = en && r && (m_count != 0);
        if (racc) begin
            m_last = sb_q.pop_front();
            m_rd   = m_rd + 4'd1;
        end
        if (wacc) begin
            sb_q.push_back(d);
            m_wr = m_wr + 4'd1;
        end
        m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
        tick();
        fifo_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'(racc));
        chk("rd_data", rd_data, m_last);
        chk_state();
    endtask

    task automatic do_reset(input logic burst);
        fifo_rst = 1'b1; fifo_en = burst; wr_en = burst; wr_data = 32'hDEAD;
        tick();
        fifo_rst = 1'b0; fifo_en = 1'b0; wr_en = 1'b0;
        sb_q.delete(); m_count = 0; m_wr = '0; m_rd = '0; m_last = '0;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk_state();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
`endif
    endtask

    task automatic do_clear();
        fifo_clr = 1'b1; fifo_en = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hBEEF;
        tick();
        fifo_clr = 1'b0; fifo_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        sb_q.delete(); m_count = 0; m_rd = m_wr;
        chk("clr_rd_valid", 32'(rd_valid), 32'd0);
        chk_state();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_underflow", 32'(underflow), 32'd0);
`endif
    endtask

    initial begin
        tick();
        do_reset(1'b0);
        chk("fwft_rst_valid", 32'(f_rd_valid), 32'd0);
        chk("fwft_rst_data", f_rd_data, 32'd0);

        // Fill 0x1..0x10, stepping count through every threshold.
        for (int i = 1; i <= 16; i++) std_cycle(1'b1, 1'b1, 32'(i), 1'b0);
        std_cycle(1'b1, 1'b1, 32'h77, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow_set", 32'(overflow), 32'd1);
`endif
        // Full: read wins, write dropped.
        std_cycle(1'b1, 1'b1, 32'h99, 1'b1);
        for (int i = 0; i < 15; i++) std_cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Empty: write wins, read dropped.
        std_cycle(1'b1, 1'b1, 32'h100, 1'b1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("underflow_set", 32'(underflow), 32'd1);
`endif
        std_cycle(1'b1, 1'b1, 32'h101, 1'b0);
        std_cycle(1'b1, 1'b1, 32'h102, 1'b0);
        for (int i = 0; i < 40; i++) std_cycle(1'b1, 1'b1, 32'h1000 + 32'(i), 1'b1);

        // Disabled: no movement, rd_valid drops.
        std_cycle(1'b0, 1'b1, 32'h55, 1'b1);
        std_cycle(1'b0, 1'b1, 32'h56, 1'b1);
        for (int i = 0; i < 3; i++) std_cycle(1'b1, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 9; i++) std_cycle(1'b1, 1'b1, 32'h200 + 32'(i), 1'b0);
        do_clear();
        std_cycle(1'b1, 1'b1, 32'h300, 1'b0);
        std_cycle(1'b1, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 5; i++) std_cycle(1'b1, 1'b1, 32'h400 + 32'(i), 1'b0);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) std_cycle(1'b1, 1'b1, 32'h500 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) std_cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // First-word-fall-through instance.
        f_en = 1'b1; f_wr_en = 1'b1; f_wr_data = 32'hA5;
        tick();
        chk("fwft_valid_1", 32'(f_rd_valid), 32'd1);
        chk("fwft_data_1", f_rd_data, 32'hA5);
        chk("fwft_count_1", 32'(f_count), 32'd1);
        f_wr_data = 32'h5A;
        tick();
        f_wr_en = 1'b0;
        chk("fwft_head_hold", f_rd_data, 32'hA5);
        chk("fwft_count_2", 32'(f_count), 32'd2);
        f_rd_en = 1'b1;
        tick();
        chk("fwft_pop_data", f_rd_data, 32'h5A);
        chk("fwft_pop_valid", 32'(f_rd_valid), 32'd1);
        tick();
        f_rd_en = 1'b0;
        chk("fwft_empty", 32'(f_empty), 32'd1);
        chk("fwft_valid_0", 32'(f_rd_valid), 32'd0);
        chk("fwft_rd_add", 32'(f_rd_add), 32'd2);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's dual-clock LUT FIFO. It is used for CPU-side peripheral buffering (UART/SPI TX/RX queues).
- Adds the following over the previous block:
  - true power-of-two depth derived from ADDR_WIDTH
  - occupancy count
  - programmable almost-full / almost-empty thresholds
  - selectable standard or first-word-fall-through (FWFT) read mode
  - synchronous flush
- Storage is a separate simple-dual-port RAM sub-module.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- ADDR_WIDTH, 4, address bits; depth is DEPTH = 2**ADDR_WIDTH (16).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock for all logic.
- fifo_rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- fifo_en  in  1  global enable; when 0, no pointer or count moves.
- fifo_clr  in  1  synchronous flush: empties the FIFO, RAM contents untouched.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (standard mode) or pop (FWFT mode).
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- wr_add  out  ADDR_WIDTH  current write address.
- rd_add  out  ADDR_WIDTH  current read address.

Behaviour:
- Reset (fifo_rst=1 at posedge) sets:
  - wr_ptr = rd_ptr = 0; count = 0
  - rd_data = 0; rd_valid = 0
  - empty = 1; full = 0; almost_empty = 1
  - almost_full = (AF_LEVEL == 0)
  - RAM is not cleared.
- Reset has priority over fifo_clr, which has priority over normal operation.
- Pointers:
  - ADDR_WIDTH+1 bits wide; the MSB is a wrap bit.
  - Address = low ADDR_WIDTH bits; pointers wrap DEPTH-1 -> 0 with the MSB toggling.
  - full = (MSBs differ) and (low bits equal); empty = (pointers equal).
- Accepted write: wr_acc = fifo_en & wr_en & !full.
  - The RAM is written at wr_ptr and wr_ptr increments at the same edge.
- Accepted read: rd_acc = fifo_en & rd_en & !empty.
  - rd_ptr increments at the edge.
- Flag evaluation uses pre-edge state, so:
  - A write while full is dropped, even if a read is accepted in the same cycle.
  - A read while empty is dropped, even if a write is accepted in the same cycle.
- count update per edge:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither occur
  - count is registered; all flags derive combinationally from the count/pointer registers.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= ram[rd_ptr]; rd_valid = 1 for exactly the following cycle, then 0.
  - rd_data holds its last value when there is no read.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rd_data = ram[rd_ptr] combinationally (LUT RAM async read); rd_valid = !empty.
  - rd_en pops the head, and the next word is visible in the following cycle.
  - Write-to-rd_valid latency from empty is 1 cycle: the word written at edge N is visible after edge N.
- fifo_clr=1:
  - rd_ptr <= wr_ptr; count <= 0; rd_valid <= 0.
  - Any wr_en or rd_en in the same cycle is ignored.
- fifo_en=0:
  - No write, no read, and no pointer change.
  - Flags hold. In standard mode rd_valid drops to 0 on the next edge.
  - Reset and clear remain active.
- wr_add = wr_ptr low bits; rd_add = rd_ptr low bits.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit, sticky): set on fifo_en & wr_en & full.
  - underflow (1 bit, sticky): set on fifo_en & rd_en & empty.
  - Both are cleared by fifo_rst or fifo_clr.
- When undefined, these ports and their logic are absent. Dropped accesses are silently ignored.

Decomposition:
- Package sync_fifo_pkg holds:
  - localparam constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1
  - function fifo_depth(addr_width) returning 2**addr_width
- Sub-module fifo_ram_sdp (parameters DATA_WIDTH, ADDR_WIDTH):
  - write port: clk, we, waddr, wdata
  - asynchronous read port: raddr -> rdata
  - no reset
- The output register for standard mode lives in sync_fifo_param.

Test Plan:
- Fill/drain (DEPTH=16, FWFT=0): write 0x1..0x10 -> full=1 and count=16 after the 16th edge. A 17th write is dropped, and count stays 16. Reading 16 words returns 0x1..0x10 in order, each with rd_valid one cycle after rd_en; then empty=1.
- Wrap-around: run 40 continuous write+read cycles with count held at 3 -> data stays in order across the pointer wrap, count stays 3, and full/empty never assert.
- Simultaneous events:
  - At count=16, wr_en=rd_en=1 -> read accepted, write dropped, count=15.
  - At count=0, wr_en=rd_en=1 -> write accepted, read dropped, count=1, rd_valid=0.
- Thresholds (AF_LEVEL=14, AE_LEVEL=2): step count 0..16 -> almost_empty=1 for counts 0..2; almost_full=1 for counts 14..16.
- FWFT=1: write 0xA5 into an empty FIFO -> the next cycle rd_valid=1 and rd_data=0xA5 with no rd_en. After a pop, empty=1 and rd_valid=0.
- Reset and clear:
  - fifo_clr at count=9 -> count=0 and empty=1 next cycle.
  - fifo_rst asserted during a write burst -> all outputs at reset values next cycle.
  - With SYNC_FIFO_ERR_FLAGS_EN defined, a write while full sets overflow, and overflow clears on fifo_clr.
